sap_controller: RTL
===================

Name: sap_controller

Overview:
Microcode sequencer for the SAP-U datapath: registers A/B, ALU, RAM/MAR, program counter, instruction register and output register.
- A step counter (T0..T4) plus the 4-bit opcode from the IR are decoded into one control word per clock.
- Supports conditional jumps on the ALU carry/zero flags, HLT, and a single-step debug mode.
- Sits at top level beside the datapath. Its outputs drive the datapath's load/enable/select pins directly.

Parameters:
- NUM_STEPS, 5, microsteps per instruction (T0..T4); counter width is 3 bits.
- EARLY_END, 1, 1 = return to T0 after an opcode's last active step; 0 = always run all NUM_STEPS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- opcode  input  4  IR[7:4]; valid from T2 onward.
- carry_flag  input  1  registered ALU carry.
- zero_flag  input  1  registered ALU zero.
- step_mode  input  1  1 = single-step, 0 = free-run.
- step_req  input  1  single-step request (level from debounced button).
- pc_out, pc_inc, pc_jump  output  1 each  program counter drive / increment / load.
- mar_load, ram_out, ram_write  output  1 each  MAR load / RAM to bus / bus to RAM.
- ir_load, ir_out  output  1 each  IR load / IR[3:0] to bus.
- a_load, a_out, b_load  output  1 each  register A and B control.
- alu_out, alu_sub, flags_load  output  1 each  ALU enable / subtract / flag register load.
- out_load  output  1  output register load.
- halted  output  1  high in HALTED state.
- step  output  3  current microstep, debug.
- instr_done  output  1  one-cycle pulse in an instruction's final step.

Behaviour:
Reset
- State: step=0, halted=0, step_req edge register=0.
- Every control output is forced to 0 combinationally while reset is high, including the T0 word.
- Reset mid-instruction aborts it; execution restarts at T0.

Timing
- The control word is decoded combinationally from the registered step, opcode and flags.
- The datapath samples it on the next rising edge, so each step's word holds for exactly one cycle.

Opcode table
- Fetch, every opcode: T0 pc_out+mar_load; T1 ram_out+ir_load+pc_inc.
- NOP 0000: no T2+ activity; last step T1.
- LDA 0001: T2 ir_out+mar_load; T3 ram_out+a_load.
- ADD 0010: T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load+flags_load.
- SUB 0011: same as ADD, plus alu_sub in T4 only.
- STA 0100: T2 ir_out+mar_load; T3 a_out+ram_write.
- LDI 0101: T2 ir_out+a_load.
- JMP 0110: T2 ir_out+pc_jump.
- JC 0111: T2 ir_out+pc_jump if carry_flag=1, else empty.
- JZ 1000: T2 ir_out+pc_jump if zero_flag=1, else empty.
- OUT 1110: T2 a_out+out_load.
- HLT 1111: T2 sets halted, registered at the end of T2.
- Undefined opcodes (1001-1101) execute as NOP.
- The last step of JC/JZ is T2 whether or not the jump is taken.

Step counter
- EARLY_END=1: after an opcode's last step, step goes to 0; otherwise step+1.
- EARLY_END=0: step wraps NUM_STEPS-1 to 0.
- instr_done is high during the step that precedes the wrap to 0.

Invariants
- At most one of pc_out, ram_out, ir_out, a_out, alu_out is high in any cycle; a violation is a bug.
- ram_write and ram_out are never both high.

Single-step
- step_mode=0: the counter advances every cycle.
- step_mode=1: the counter advances only in the cycle after a rising edge of step_req (0 to 1 against the registered copy).
- A held step_req advances exactly once.
- Control outputs are held during the wait, but load/write/inc/jump/flags_load strobes are gated to the single advancing cycle, so a held word never double-loads.
- step_mode may change between steps; a change takes effect on the next edge.

HALTED
- step frozen; all control outputs 0; halted=1.
- step_req and step_mode are ignored.
- Exit only via reset.

Decomposition:
- Shared package sap_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - step constants T0..T4;
  - control-word bit indices, so the datapath top and the testbench can pack/unpack a 16-bit control vector.
- One sub-module, sap_step_counter. It owns:
  - the 3-bit counter;
  - EARLY_END/last-step wrap;
  - step_req edge detect and step_mode gating;
  - the halt freeze.
- The opcode/step decode stays in sap_controller.

Test Plan:
1. Reset during T3 of LDA → all controls 0 immediately; after release, step=0 and the T0 word is pc_out=1, mar_load=1.
2. Free-run ADD, EARLY_END=1 → T0..T4 words exactly as tabled; instr_done high in T4; step returns to 0; 5 cycles total.
3. JC with carry_flag=0 then carry_flag=1 → T2 empty vs ir_out+pc_jump; both instructions take 3 cycles; instr_done in T2.
4. EARLY_END=0, LDI → T3 and T4 empty; wrap to 0 after T4.
5. step_mode=1, step_req held high 10 cycles → exactly one step advance; a_load/mar_load each pulse for 1 cycle only.
6. HLT → halted=1 from T3 onward; step frozen; step_req pulses ignored; reset clears halted to 0.
- All scenarios: one-hot bus-driver assertion checked every cycle.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-U sequencer: opcodes, microstep numbers and
// control-word bit positions used to pack/unpack the 16-bit control vector.
package sap_pkg;

    localparam int CW_WIDTH = 16;
    typedef logic [CW_WIDTH-1:0] cw_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam int CW_PC_OUT     = 0;
    localparam int CW_PC_INC     = 1;
    localparam int CW_PC_JUMP    = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_RAM_OUT    = 4;
    localparam int CW_RAM_WRITE  = 5;
    localparam int CW_IR_LOAD    = 6;
    localparam int CW_IR_OUT     = 7;
    localparam int CW_A_LOAD     = 8;
    localparam int CW_A_OUT      = 9;
    localparam int CW_B_LOAD     = 10;
    localparam int CW_ALU_OUT    = 11;
    localparam int CW_ALU_SUB    = 12;
    localparam int CW_FLAGS_LOAD = 13;
    localparam int CW_OUT_LOAD   = 14;
    // Internal halt request; not routed to the datapath.
    localparam int CW_HALT       = 15;

    function automatic cw_t cw_bit(input int idx);
        return cw_t'(1) << idx;
    endfunction

    // Edge-triggered bits: only allowed high in the cycle the step counter advances.
    localparam cw_t CW_STROBES = cw_bit(CW_PC_INC) | cw_bit(CW_PC_JUMP) | cw_bit(CW_MAR_LOAD)
                               | cw_bit(CW_RAM_WRITE) | cw_bit(CW_IR_LOAD) | cw_bit(CW_A_LOAD)
                               | cw_bit(CW_B_LOAD) | cw_bit(CW_FLAGS_LOAD) | cw_bit(CW_OUT_LOAD)
                               | cw_bit(CW_HALT);

    function automatic logic [2:0] last_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA:                                return T3;
            OP_ADD, OP_SUB:                                return T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:  return T2;
            default:                                       return T1;
        endcase
    endfunction

endpackage

// File: rtl/sap_step_counter.sv
// Microstep counter with early-end wrap, single-step request edge detect
// and halt freeze.
module sap_step_counter
    import sap_pkg::*;
#(
    parameter int NUM_STEPS = 5,
    parameter int EARLY_END = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_mode,
    input  logic       step_req,
    input  logic       last_hit,
    input  logic       halt_req,
    output logic [2:0] step,
    output logic       halted,
    output logic       advance,
    output logic       instr_done
);

    localparam logic [2:0] LAST_T = 3'(NUM_STEPS - 1);
    localparam bit         EARLY  = (EARLY_END != 0);

    logic req_q;
    logic wrap;

    assign advance    = !halted && (!step_mode || (step_req && !req_q));
    assign wrap       = (step == LAST_T) || (EARLY && last_hit);
    assign instr_done = advance && wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step   <= T0;
            halted <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            req_q <= step_req;
            if (advance) begin
                // A halting instruction leaves step parked where it stopped.
                if (halt_req) begin
                    halted <= 1'b1;
                end else if (wrap) begin
                    step <= T0;
                end else begin
                    step <= step + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sap_controller.sv
// SAP-U microcode sequencer: decodes the registered microstep, opcode and ALU
// flags into one datapath control word per clock.
module sap_controller
    import sap_pkg::*;
#(
    parameter int NUM_STEPS = 5,
    parameter int EARLY_END = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    input  logic       step_mode,
    input  logic       step_req,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_jump,
    output logic       mar_load,
    output logic       ram_out,
    output logic       ram_write,
    output logic       ir_load,
    output logic       ir_out,
    output logic       a_load,
    output logic       a_out,
    output logic       b_load,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       halted,
    output logic [2:0] step,
    output logic       instr_done
);

    cw_t  word;
    cw_t  gated;
    logic advance;
    logic done_raw;
    logic is_last;

    always_comb begin
        word = '0;
        case (step)
            T0: word = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
            T1: word = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD) | cw_bit(CW_PC_INC);
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        word = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
                    OP_LDI: word = cw_bit(CW_IR_OUT) | cw_bit(CW_A_LOAD);
                    OP_JMP: word = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_JUMP);
                    OP_JC: begin
                        if (carry_flag) word = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_JUMP);
                    end
                    OP_JZ: begin
                        if (zero_flag) word = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_JUMP);
                    end
                    OP_OUT: word = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
                    OP_HLT: word = cw_bit(CW_HALT);
                    default: word = '0;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA:         word = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
                    OP_ADD, OP_SUB: word = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
                    OP_STA:         word = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_WRITE);
                    default:        word = '0;
                endcase
            end
            T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    word = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD) | cw_bit(CW_FLAGS_LOAD);
                    if (opcode == OP_SUB) word = word | cw_bit(CW_ALU_SUB);
                end
            end
            default: word = '0;
        endcase
    end

    // Bus drivers and alu_sub stay up while single-step waits; strobes fire once.
    always_comb begin
        gated = word;
        if (!advance) gated = gated & ~CW_STROBES;
        if (reset || halted) gated = '0;
    end

    assign is_last = (step == last_step(opcode));

    sap_step_counter #(
        .NUM_STEPS (NUM_STEPS),
        .EARLY_END (EARLY_END)
    ) u_step_counter (
        .clk        (clk),
        .reset      (reset),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .last_hit   (is_last),
        .halt_req   (gated[CW_HALT]),
        .step       (step),
        .halted     (halted),
        .advance    (advance),
        .instr_done (done_raw)
    );

    assign pc_out     = gated[CW_PC_OUT];
    assign pc_inc     = gated[CW_PC_INC];
    assign pc_jump    = gated[CW_PC_JUMP];
    assign mar_load   = gated[CW_MAR_LOAD];
    assign ram_out    = gated[CW_RAM_OUT];
    assign ram_write  = gated[CW_RAM_WRITE];
    assign ir_load    = gated[CW_IR_LOAD];
    assign ir_out     = gated[CW_IR_OUT];
    assign a_load     = gated[CW_A_LOAD];
    assign a_out      = gated[CW_A_OUT];
    assign b_load     = gated[CW_B_LOAD];
    assign alu_out    = gated[CW_ALU_OUT];
    assign alu_sub    = gated[CW_ALU_SUB];
    assign flags_load = gated[CW_FLAGS_LOAD];
    assign out_load   = gated[CW_OUT_LOAD];
    assign instr_done = done_raw && !reset;

endmodule
